// File: rtl/cam_pkg.sv
// cam_pkg: shared encodings and colour tables for the camera pattern generator.
//   mode_e  - pattern select (solid, blue/green pairs, 8 bars, checkerboard)
//   fmt_e   - output pixel format (RGB444 / RGB565)
//   state_e - generator run state
//   BAR_444 / BAR_565 - the 8 bar colours, white first, black last
package cam_pkg;
  typedef enum logic [1:0] {MODE_SOLID, MODE_PAIRS, MODE_BARS, MODE_CHECK} mode_e;
  typedef enum logic {FMT_444, FMT_565} fmt_e;
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [2:0] BAR_WHITE = 3'd0, BAR_GREEN = 3'd3, BAR_BLUE = 3'd6, BAR_BLACK = 3'd7;
  localparam logic [0:7][11:0] BAR_444 = {12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};
  localparam logic [0:7][15:0] BAR_565 = {16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  // RGB444 colours are returned right-aligned in the low 12 bits.
  function automatic logic [15:0] bar_color(input logic [2:0] idx, input fmt_e f);
    return f == FMT_565 ? BAR_565[idx] : {4'h0, BAR_444[idx]};
  endfunction
endpackage

// File: rtl/cam_pixel_fmt.sv
// cam_pixel_fmt: splits one pixel colour into the camera byte stream.
//   pix_color - pixel colour (RGB444 in [11:0] or RGB565)
//   fmt       - output format
//   phase     - 0 = first byte of the pixel, 1 = second byte
//   valid     - active byte slot; data is forced to 0 otherwise
//   data      - output byte
module cam_pixel_fmt
  import cam_pkg::*;
(
  input  logic [15:0] pix_color,
  input  fmt_e        fmt,
  input  logic        phase,
  input  logic        valid,
  output logic [7:0]  data
);
  assign data = !valid ? 8'h00 :
                phase ? pix_color[7:0] :
                fmt == FMT_565 ? pix_color[15:8] : {4'h0, pix_color[11:8]};
endmodule

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: OV-style camera emulator producing test patterns.
//   clk, rst            - system clock, synchronous active-high reset
//   en                  - run frames; a frame in progress always completes
//   mode, fmt, color    - pattern, byte format, solid colour (taken at frame start)
//   CAM_pclk            - pixel clock, low for the first half of each byte slot
//   CAM_vsync, CAM_href - frame sync and active-byte qualifier
//   CAM_px_data         - byte stream, 0 outside active bytes
//   frame_done          - one-clk pulse in the last clk of a frame
//   frame_cnt           - completed frame count
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int H_BLANK  = 4,
  parameter int V_BLANK  = 4,
  parameter int V_SYNC   = 2,
  parameter int PCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic        fmt,
  input  logic [15:0] color,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);
  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME = V_BLANK + V_ACTIVE;
  localparam int HW    = $clog2(LINE);
  localparam int VW    = $clog2(FRAME);
  localparam int DW    = $clog2(PCLK_DIV);
  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  state_e        state, nxt;
  mode_e         mode_q;
  fmt_e          fmt_q;
  logic [15:0]   color_q, pix_color;
  logic [2:0]    bar;
  logic          run, slot_end, line_end, frame_end, start;
  assign run        = state == RUN;
  assign slot_end   = div == DW'(PCLK_DIV - 1);
  assign line_end   = h == HW'(LINE - 1);
  assign frame_end  = v == VW'(FRAME - 1);
  assign frame_done = !rst && run && slot_end && line_end && frame_end;
  // Configuration is captured on the edge that enters line 0, slot 0.
  assign start      = slot_end && (run ? line_end && frame_end : en);
  assign CAM_pclk   = div >= DW'(PCLK_DIV / 2);
  assign CAM_vsync  = run && v < VW'(V_SYNC);
  assign CAM_href   = run && v >= VW'(V_BLANK) && h < HW'(2 * H_ACTIVE);
  always_comb nxt = run ? ((frame_done && !en) ? IDLE : RUN) : ((slot_end && en) ? RUN : IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
      mode_q    <= MODE_SOLID;
      fmt_q     <= FMT_444;
      color_q   <= '0;
    end else begin
      state <= nxt;
      div   <= slot_end ? '0 : div + 1'b1;
      if (slot_end && run) begin
        h <= line_end ? '0 : h + 1'b1;
        if (line_end) v <= frame_end ? '0 : v + 1'b1;
      end
      if (start) begin
        mode_q  <= mode_e'(mode);
        fmt_q   <= fmt_e'(fmt);
        color_q <= color;
      end
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end
  // Pixel index is h>>1; pairs alternate on pixel bit 1, tiles on pixel/row bit 3.
  always_comb begin
    bar       = 3'((32'(h >> 1) * 8) / H_ACTIVE);
    pix_color = mode_q == MODE_SOLID ? color_q :
                bar_color(mode_q == MODE_PAIRS ? (1'(h >> 2) ? BAR_GREEN : BAR_BLUE) :
                          mode_q == MODE_BARS  ? bar :
                          (1'(h >> 4) ^ 1'((v - VW'(V_BLANK)) >> 3)) ? BAR_WHITE : BAR_BLACK,
                          fmt_q);
  end
  cam_pixel_fmt u_fmt (
    .pix_color(pix_color),
    .fmt      (fmt_q),
    .phase    (h[0]),
    .valid    (CAM_href),
    .data     (CAM_px_data)
  );
endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb_cam_pattern_gen: directed bench for cam_pattern_gen on a reduced frame size.
module tb_cam_pattern_gen;
  localparam int HA = 16, VA = 16, HB = 4, VB = 4, VS = 2, PD = 4;
  localparam int LINE = 2 * HA + HB;
  localparam int LCLK = LINE * PD;
  localparam int FCLK = (VB + VA) * LCLK;
  logic        clk = 0, rst = 1, en = 0, fmt = 0;
  logic [1:0]  mode = 0;
  logic [15:0] color = 0;
  logic        CAM_pclk, CAM_vsync, CAM_href, frame_done;
  logic [7:0]  CAM_px_data;
  logic [15:0] frame_cnt;
  logic [7:0]  fb [VA][2*HA];
  logic [15:0] exp_cnt = 0;
  int          checks = 0, errors = 0;
  typedef struct {
    logic [1:0]  mode;
    logic        fmt;
    logic [15:0] color;
    int          row;
    int          pix;
    logic [15:0] exp;
  } vec_t;
  vec_t tv [20];

  cam_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
                    .V_SYNC(VS), .PCLK_DIV(PD)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fmt(fmt), .color(color),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // From idle: raise en one negedge before a slot boundary, so the next negedge is frame clk 0.
  task automatic sync_start();
    logic pp = 0, found = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (CAM_pclk && pp) begin
        en = 1;
        found = 1;
        break;
      end
      pp = CAM_pclk;
    end
    check("sync_start", found, 1);
  endtask

  // Captures one full frame starting at the next negedge; act 1 = set mode, 2 = drop en.
  task automatic capture_frame(input int act_line, input int act, input logic [1:0] amode);
    int vs_clks = 0, href_rise = 0, pclk_err = 0, hv_err = 0, stab_err = 0, fd_early = 0, cnt_err = 0;
    int line, slot;
    logic exp_h, exp_v, last_fd = 0, prev_h = 0;
    logic [7:0] prev_d = 0;
    for (int k = 0; k < FCLK; k++) begin
      @(negedge clk);
      if (act != 0 && k == act_line * LCLK) begin
        if (act == 1) mode = amode;
        else en = 0;
      end
      line  = k / LCLK;
      slot  = (k / PD) % LINE;
      exp_h = line >= VB && slot < 2 * HA;
      exp_v = line < VS;
      if (CAM_pclk !== ((k % PD) >= PD / 2)) pclk_err++;
      if (CAM_href !== exp_h || CAM_vsync !== exp_v || (!exp_h && CAM_px_data !== 8'h00)) hv_err++;
      if (k % PD != 0 && (CAM_href !== prev_h || CAM_px_data !== prev_d)) stab_err++;
      if (CAM_href && !prev_h) href_rise++;
      if (CAM_vsync) vs_clks++;
      if (exp_h && k % PD == PD / 2) fb[line-VB][slot] = CAM_px_data;
      if (frame_done && k != FCLK - 1) fd_early++;
      if (k == FCLK - 1) last_fd = frame_done;
      if ((k == 0 || k == FCLK - 1) && frame_cnt !== exp_cnt) cnt_err++;
      prev_h = CAM_href;
      prev_d = CAM_px_data;
    end
    check("pclk_wave", pclk_err, 0);
    check("href_vsync_timing", hv_err, 0);
    check("slot_stability", stab_err, 0);
    check("vsync_clks", vs_clks, VS * LCLK);
    check("href_pulses", href_rise, VA);
    check("frame_done_early", fd_early, 0);
    check("frame_done_end", last_fd, 1);
    check("frame_cnt", cnt_err, 0);
    exp_cnt++;
  endtask

  initial begin
    int rises, bad, waited;
    logic pp, found, fd;
    tv[0]  = '{2'd1, 1'b0, 16'h0000, 0, 0, 16'h000F};
    tv[1]  = '{2'd1, 1'b0, 16'h0000, 3, 2, 16'h00F0};
    tv[2]  = '{2'd1, 1'b0, 16'h0000, 15, 5, 16'h000F};
    tv[3]  = '{2'd1, 1'b0, 16'h0000, 7, 15, 16'h00F0};
    tv[4]  = '{2'd0, 1'b1, 16'hF800, 0, 3, 16'hF800};
    tv[5]  = '{2'd0, 1'b1, 16'hF800, 10, 15, 16'hF800};
    tv[6]  = '{2'd0, 1'b0, 16'h00F0, 4, 6, 16'h00F0};
    tv[7]  = '{2'd0, 1'b0, 16'hA5C3, 2, 1, 16'h05C3};
    tv[8]  = '{2'd2, 1'b1, 16'h0000, 0, 0, 16'hFFFF};
    tv[9]  = '{2'd2, 1'b1, 16'h0000, 0, 2, 16'hFFE0};
    tv[10] = '{2'd2, 1'b1, 16'h0000, 5, 9, 16'hF81F};
    tv[11] = '{2'd2, 1'b1, 16'h0000, 5, 15, 16'h0000};
    tv[12] = '{2'd2, 1'b0, 16'h0000, 1, 4, 16'h00FF};
    tv[13] = '{2'd2, 1'b0, 16'h0000, 1, 10, 16'h0F00};
    tv[14] = '{2'd3, 1'b0, 16'h0000, 0, 0, 16'h0000};
    tv[15] = '{2'd3, 1'b0, 16'h0000, 0, 8, 16'h0FFF};
    tv[16] = '{2'd3, 1'b0, 16'h0000, 8, 0, 16'h0FFF};
    tv[17] = '{2'd3, 1'b0, 16'h0000, 8, 8, 16'h0000};
    tv[18] = '{2'd3, 1'b1, 16'h0000, 9, 4, 16'hFFFF};
    tv[19] = '{2'd1, 1'b1, 16'h0000, 0, 3, 16'h07E0};

    repeat (3) @(negedge clk);
    check("rst_pclk", CAM_pclk, 0);
    check("rst_vsync", CAM_vsync, 0);
    check("rst_href", CAM_href, 0);
    check("rst_data", CAM_px_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 0;
    rises = 0; bad = 0; pp = CAM_pclk;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (CAM_vsync || CAM_href || CAM_px_data != 0 || frame_done) bad++;
      if (CAM_pclk && !pp) rises++;
      pp = CAM_pclk;
    end
    check("idle_quiet", bad, 0);
    check("idle_pclk_rises", rises, 10);

    for (int i = 0; i < 20; i++) begin
      if (i == 0 || tv[i].mode != tv[i-1].mode || tv[i].fmt != tv[i-1].fmt || tv[i].color != tv[i-1].color) begin
        mode = tv[i].mode; fmt = tv[i].fmt; color = tv[i].color;
        if (i == 0) sync_start();
        capture_frame(0, 0, 2'd0);
      end
      check($sformatf("vec%0d_m%0d_f%0d_r%0d_p%0d", i, tv[i].mode, tv[i].fmt, tv[i].row, tv[i].pix),
            {fb[tv[i].row][2*tv[i].pix], fb[tv[i].row][2*tv[i].pix+1]}, tv[i].exp);
    end

    mode = 2'd1; fmt = 1'b1; color = 16'h0000;
    capture_frame(0, 0, 2'd0);
    capture_frame(10, 1, 2'd2);
    check("switch_cur_pix0", {fb[0][0], fb[0][1]}, 16'h001F);
    check("switch_cur_pix2", {fb[15][4], fb[15][5]}, 16'h07E0);
    capture_frame(0, 0, 2'd0);
    check("switch_next_pix0", {fb[0][0], fb[0][1]}, 16'hFFFF);
    check("switch_next_pix1", {fb[3][2], fb[3][3]}, 16'hFFFF);
    check("switch_next_pix2", {fb[0][4], fb[0][5]}, 16'hFFE0);

    capture_frame(5, 2, 2'd0);
    rises = 0; bad = 0; pp = CAM_pclk;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (CAM_vsync || CAM_href || CAM_px_data != 0 || frame_done) bad++;
      if (CAM_pclk && !pp) rises++;
      pp = CAM_pclk;
    end
    check("endrop_quiet", bad, 0);
    check("endrop_pclk_rises", rises, 100);
    check("endrop_frame_cnt", frame_cnt, exp_cnt);

    mode = 2'd1; fmt = 1'b0;
    sync_start();
    repeat (10 * LCLK + 7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_mid_outputs", {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, frame_cnt}, 0);
    rst = 0;
    exp_cnt = 0;
    found = 0; fd = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (frame_done) fd = 1;
      if (CAM_vsync) begin
        found = 1;
        break;
      end
    end
    check("rst_restart_vsync", found, 1);
    check("rst_no_frame_done", fd, 0);
    waited = 0; found = 0;
    for (int n = 0; n < FCLK + 8; n++) begin
      @(negedge clk);
      if (frame_done) begin
        waited = n + 1;
        found = 1;
        break;
      end
    end
    check("rst_frame_len", waited, FCLK - 1);
    if (found) exp_cnt = 1;
    capture_frame(0, 0, 2'd0);
    check("rst_after_pix1", {fb[0][2], fb[0][3]}, 16'h000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
